// File: rtl/pcie_tlp_tx_gen.sv
// PCIe memory request TLP generator: splits byte-addressed read/write requests
// into MPS/MRRS-limited, 4KB-safe TLPs on a 256-bit streaming output.

package pcie_pkg;

  // 16B memory request header; byte 0 of the wire format sits in bits [7:0]
  typedef struct packed {
    logic [5:0] addr_l;          // byte 15
    logic [1:0] ph;
    logic [7:0] addr_15_8;       // byte 14
    logic [7:0] addr_23_16;      // byte 13
    logic [7:0] addr_31_24;      // byte 12
    logic [7:0] addr_39_32;      // byte 11
    logic [7:0] addr_47_40;      // byte 10
    logic [7:0] addr_55_48;      // byte 9
    logic [7:0] addr_63_56;      // byte 8
    logic [3:0] last_be;         // byte 7
    logic [3:0] first_be;
    logic [7:0] tag_l;           // byte 6
    logic [7:0] requester_id_l;  // byte 5
    logic [7:0] requester_id_h;  // byte 4
    logic [7:0] length_l;        // byte 3
    logic       td;              // byte 2
    logic       ep;
    logic [1:0] attr_l;
    logic [1:0] at;
    logic [1:0] length_h;
    logic       tag_h9;          // byte 1
    logic [2:0] tc;
    logic       tag_h8;
    logic       attr_h;
    logic       ln;
    logic       th;
    logic [2:0] fmt;             // byte 0
    logic [4:0] tlp_type;
  } tlp_memory_req_header_t;

endpackage

module pcie_tlp_tx_gen
  import pcie_pkg::*;
#(
  parameter int unsigned MPS  = 128,
  parameter int unsigned MRRS = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [63:0]  req_addr,
  input  logic [12:0]  req_len,
  input  logic         wdata_valid,
  output logic         wdata_ready,
  input  logic [255:0] wdata,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] tx_data,
  output logic         tx_sop,
  output logic         tx_eop
);

  localparam int unsigned AW  = 64;
  localparam int unsigned LW  = 13;
  localparam int unsigned DW  = 256;
  localparam int unsigned BCW = 8;
  localparam int unsigned TW  = 8;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [LW-1:0]   chunk_q, chunk_d;
  logic [BCW-1:0]  beats_q, beats_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_sop_q, tx_sop_d;
  logic            tx_eop_q, tx_eop_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;

  logic                   tx_free;
  logic [AW-1:0]          lat_addr;
  logic [LW-1:0]          lat_len;
  logic [LW-1:0]          chunk_c;
  logic [AW-1:0]          rd_next_addr, wr_next_addr;
  logic [LW-1:0]          rd_next_rem, wr_next_rem;
  tlp_memory_req_header_t hdr_c;

  // Largest legal TLP at this address: remaining, size limit, distance to 4KB edge
  function automatic logic [LW-1:0] calc_chunk(input logic [AW-1:0] addr,
                                               input logic [LW-1:0] rem,
                                               input logic          wr);
    logic [LW-1:0] lim;
    logic [LW-1:0] to_bnd;
    logic [LW-1:0] c;
    lim    = wr ? LW'(MPS) : LW'(MRRS);
    to_bnd = LW'(4096) - LW'(12'(addr));
    c      = rem;
    if (lim < c)    c = lim;
    if (to_bnd < c) c = to_bnd;
    return c;
  endfunction

  function automatic tlp_memory_req_header_t build_header(input logic          wr,
                                                          input logic [AW-1:0] addr,
                                                          input logic [LW-1:0] chunk,
                                                          input logic [TW-1:0] tag);
    tlp_memory_req_header_t h;
    logic [9:0] len_dw;
    len_dw           = 10'(chunk >> 2);
    h                = '0;
    h.fmt            = wr ? 3'b011 : 3'b001;
    h.tlp_type       = 5'b00000;
    h.length_h       = len_dw[9:8];
    h.length_l       = len_dw[7:0];
    h.requester_id_h = 8'h02;
    h.requester_id_l = 8'h00;
    h.tag_l          = wr ? 8'h00 : tag;
    h.last_be        = 4'hF;
    h.first_be       = 4'hF;
    h.addr_63_56     = addr[63:56];
    h.addr_55_48     = addr[55:48];
    h.addr_47_40     = addr[47:40];
    h.addr_39_32     = addr[39:32];
    h.addr_31_24     = addr[31:24];
    h.addr_23_16     = addr[23:16];
    h.addr_15_8      = addr[15:8];
    h.addr_l         = 6'(addr >> 2);
    return h;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      beats_q    <= '0;
      tag_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      chunk_q    <= chunk_d;
      beats_q    <= beats_d;
      tag_q      <= tag_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state, handshakes and output register loads
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    chunk_d      = chunk_q;
    beats_d      = beats_q;
    tag_d        = tag_q;
    tx_valid_d   = tx_valid_q;
    tx_sop_d     = tx_sop_q;
    tx_eop_d     = tx_eop_q;
    tx_data_d    = tx_data_q;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;

    tx_free      = !tx_valid_q || tx_ready;
    lat_addr     = req_addr & ~AW'(32'h1F);
    lat_len      = req_len & ~LW'(5'h1F);
    chunk_c      = calc_chunk(addr_q, rem_q, wr_q);
    hdr_c        = build_header(wr_q, addr_q, chunk_c, tag_q);
    rd_next_addr = addr_q + AW'(chunk_c);
    rd_next_rem  = rem_q - chunk_c;
    wr_next_addr = addr_q + AW'(chunk_q);
    wr_next_rem  = rem_q - chunk_q;

    // Slot drains when the sink takes the beat; a load below may refill it
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
      tx_sop_d   = 1'b0;
      tx_eop_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && lat_len != '0) begin
          wr_d    = req_wr;
          addr_d  = lat_addr;
          rem_d   = lat_len;
          state_d = HDR;
        end
      end

      HDR: begin
        if (tx_free) begin
          tx_valid_d = 1'b1;
          tx_sop_d   = 1'b1;
          tx_eop_d   = !wr_q;
          tx_data_d  = {128'd0, hdr_c};
          chunk_d    = chunk_c;
          if (wr_q) begin
            beats_d = BCW'(chunk_c >> 5);
            state_d = DATA;
          end else begin
            addr_d  = rd_next_addr;
            rem_d   = rd_next_rem;
            tag_d   = tag_q + TW'(1);
            state_d = (rd_next_rem != '0) ? HDR : IDLE;
          end
        end
      end

      DATA: begin
        wdata_ready = tx_free;
        if (wdata_valid && tx_free) begin
          tx_valid_d = 1'b1;
          tx_sop_d   = 1'b0;
          tx_eop_d   = (beats_q == BCW'(1));
          tx_data_d  = wdata;
          beats_d    = beats_q - BCW'(1);
          if (beats_q == BCW'(1)) begin
            addr_d  = wr_next_addr;
            rem_d   = wr_next_rem;
            state_d = (wr_next_rem != '0) ? HDR : IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = tx_valid_q;
  assign tx_sop   = tx_sop_q;
  assign tx_eop   = tx_eop_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_pcie_tlp_tx_gen.sv
// Directed bench for pcie_tlp_tx_gen: header encoding, splitting, stalls,
// tag wrap and reset behaviour.

module tb_pcie_tlp_tx_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wr = 1'b0;
  logic [63:0]  req_addr = '0;
  logic [12:0]  req_len = '0;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [255:0] wdata;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [255:0] tx_data;
  logic         tx_sop;
  logic         tx_eop;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [255:0] wq[$];
  logic         rand_wv = 1'b0;
  logic         hs;
  logic [255:0] cap_data[$];
  logic         cap_sop[$];
  logic         cap_eop[$];
  int           cap_cyc[$];
  logic [7:0]   exp_tag = 8'h00;

  pcie_tlp_tx_gen dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      cap_data.push_back(tx_data);
      cap_sop.push_back(tx_sop);
      cap_eop.push_back(tx_eop);
      cap_cyc.push_back(cyc);
    end
  end

  // Payload source: presents wq[0], pops on handshake
  initial begin
    wdata_valid = 1'b0;
    wdata = '0;
    forever begin
      @(posedge clk);
      hs = wdata_valid && wdata_ready;
      #1;
      if (hs && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && (!rand_wv || $urandom_range(0, 1) == 1)) begin
        wdata_valid = 1'b1;
        wdata = wq[0];
      end else begin
        wdata_valid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] exp_hdr(input logic wr, input logic [63:0] a,
                                           input int unsigned nbytes, input logic [7:0] tag);
    logic [255:0] d;
    logic [9:0] dw;
    d = '0;
    dw = 10'(nbytes / 4);
    d[7:0]   = wr ? 8'h60 : 8'h20;
    d[23:16] = {6'b0, dw[9:8]};
    d[31:24] = dw[7:0];
    d[39:32] = 8'h02;
    d[55:48] = wr ? 8'h00 : tag;
    d[63:56] = 8'hFF;
    for (int i = 0; i < 8; i++) d[64 + 8*i +: 8] = a[63 - 8*i -: 8];
    d[127:120] = {a[7:2], 2'b00};
    return d;
  endfunction

  function automatic logic [255:0] pay(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  task automatic clear_cap();
    cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
  endtask

  task automatic send_req(input logic wr, input logic [63:0] a, input logic [12:0] l);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (req_ready && !tx_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    n_cmp++; if (tx_sop !== 1'b0 || tx_eop !== 1'b0) begin n_bad++; $display("FAIL reset_sop_eop got %b%b exp 00", tx_sop, tx_eop); end
    n_cmp++; if (tx_data !== '0) begin n_bad++; $display("FAIL reset_tx_data got %h exp 0", tx_data); end
    n_cmp++; if (wdata_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wdata_ready got %b exp 0", wdata_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_single_write();
    logic ok;
    tx_ready = 1'b1;
    clear_cap();
    for (int i = 0; i < 4; i++) wq.push_back(pay(32'hC0DE_0000 + 32'(i)));
    @(posedge clk); #1;
    send_req(1'b1, 64'h1000, 13'd128);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL wr1_latency_early got %b exp 0", tx_valid); end
    @(posedge clk); #1;
    n_cmp++; if (tx_valid !== 1'b1 || tx_sop !== 1'b1) begin n_bad++; $display("FAIL wr1_latency got v=%b sop=%b exp 1/1", tx_valid, tx_sop); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wr1_req_ready_busy got %b exp 0", req_ready); end
    wait_idle(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr1_timeout got %b exp 1", ok); end
    n_cmp++; if (cap_data.size() != 5) begin n_bad++; $display("FAIL wr1_beats got %0d exp 5", cap_data.size()); end
    for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
      logic [255:0] ed;
      ed = (i == 0) ? exp_hdr(1'b1, 64'h1000, 128, 8'h00) : pay(32'hC0DE_0000 + 32'(i - 1));
      n_cmp++; if (cap_data[i] !== ed) begin n_bad++; $display("FAIL wr1_data[%0d] got %h exp %h", i, cap_data[i], ed); end
      n_cmp++; if (cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == 4)) begin n_bad++; $display("FAIL wr1_flags[%0d] got sop=%b eop=%b", i, cap_sop[i], cap_eop[i]); end
      n_cmp++; if (cap_cyc[i] != cap_cyc[0] + i) begin n_bad++; $display("FAIL wr1_bubble[%0d] got cyc %0d exp %0d", i, cap_cyc[i], cap_cyc[0] + i); end
    end
  endtask

  task automatic test_boundary_write();
    logic ok;
    logic [255:0] ed[$];
    logic es[$], ee[$];
    int pi;
    clear_cap();
    for (int i = 0; i < 8; i++) wq.push_back(pay(32'hB00B_0000 + 32'(i)));
    @(posedge clk); #1;
    send_req(1'b1, 64'h0FC0, 13'd256);
    wait_idle(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bnd_timeout got %b exp 1", ok); end
    pi = 0;
    ed.push_back(exp_hdr(1'b1, 64'h0FC0, 64, 8'h00)); es.push_back(1'b1); ee.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin ed.push_back(pay(32'hB00B_0000 + 32'(pi))); pi++; es.push_back(1'b0); ee.push_back(i == 1); end
    ed.push_back(exp_hdr(1'b1, 64'h1000, 128, 8'h00)); es.push_back(1'b1); ee.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin ed.push_back(pay(32'hB00B_0000 + 32'(pi))); pi++; es.push_back(1'b0); ee.push_back(i == 3); end
    ed.push_back(exp_hdr(1'b1, 64'h1080, 64, 8'h00)); es.push_back(1'b1); ee.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin ed.push_back(pay(32'hB00B_0000 + 32'(pi))); pi++; es.push_back(1'b0); ee.push_back(i == 1); end
    n_cmp++; if (cap_data.size() != 11) begin n_bad++; $display("FAIL bnd_beats got %0d exp 11", cap_data.size()); end
    for (int i = 0; i < 11 && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== ed[i]) begin n_bad++; $display("FAIL bnd_data[%0d] got %h exp %h", i, cap_data[i], ed[i]); end
      n_cmp++; if (cap_sop[i] !== es[i] || cap_eop[i] !== ee[i]) begin n_bad++; $display("FAIL bnd_flags[%0d] got %b%b exp %b%b", i, cap_sop[i], cap_eop[i], es[i], ee[i]); end
    end
  endtask

  task automatic test_read();
    logic ok;
    clear_cap();
    send_req(1'b0, 64'h2000, 13'd1024);
    wait_idle(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_timeout got %b exp 1", ok); end
    n_cmp++; if (cap_data.size() != 2) begin n_bad++; $display("FAIL rd_beats got %0d exp 2", cap_data.size()); end
    for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
      logic [255:0] e;
      e = exp_hdr(1'b0, 64'h2000 + 64'(512 * i), 512, exp_tag);
      n_cmp++; if (cap_data[i] !== e) begin n_bad++; $display("FAIL rd_hdr[%0d] got %h exp %h", i, cap_data[i], e); end
      n_cmp++; if (cap_sop[i] !== 1'b1 || cap_eop[i] !== 1'b1) begin n_bad++; $display("FAIL rd_flags[%0d] got %b%b exp 11", i, cap_sop[i], cap_eop[i]); end
      exp_tag = exp_tag + 8'd1;
    end
  endtask

  task automatic test_stall();
    logic stalled, ps, pe;
    logic [255:0] pd;
    clear_cap();
    rand_wv = 1'b1;
    for (int i = 0; i < 4; i++) wq.push_back(pay(32'h5A11_0000 + 32'(i)));
    @(posedge clk); #1;
    send_req(1'b1, 64'h3000, 13'd128);
    stalled = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (stalled) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== pd || tx_sop !== ps || tx_eop !== pe) begin
          n_bad++; $display("FAIL stall_hold got v=%b sop=%b eop=%b data=%h exp data=%h", tx_valid, tx_sop, tx_eop, tx_data, pd);
        end
      end
      if (cap_data.size() >= 5 && !tx_valid) break;
      tx_ready = ~tx_ready;
      stalled = tx_valid && !tx_ready;
      pd = tx_data; ps = tx_sop; pe = tx_eop;
    end
    tx_ready = 1'b1;
    rand_wv = 1'b0;
    n_cmp++; if (cap_data.size() != 5) begin n_bad++; $display("FAIL stall_beats got %0d exp 5", cap_data.size()); end
    for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
      logic [255:0] e;
      e = (i == 0) ? exp_hdr(1'b1, 64'h3000, 128, 8'h00) : pay(32'h5A11_0000 + 32'(i - 1));
      n_cmp++; if (cap_data[i] !== e || cap_eop[i] !== (i == 4)) begin n_bad++; $display("FAIL stall_data[%0d] got %h eop=%b exp %h", i, cap_data[i], cap_eop[i], e); end
    end
  endtask

  task automatic test_zero_len();
    clear_cap();
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %b exp 1", req_ready); end
    send_req(1'b1, 64'h4000, 13'd0);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_idle got %b exp 1", req_ready); end
    repeat (6) begin @(posedge clk); #1; end
    n_cmp++; if (cap_data.size() != 0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL zero_beats got %0d exp 0", cap_data.size()); end
  endtask

  task automatic test_tag_wrap();
    logic ok, wrap_seen;
    logic [7:0] prev;
    logic [63:0] base;
    wrap_seen = 1'b0;
    prev = 8'h00;
    for (int k = 0; k < 33; k++) begin
      clear_cap();
      base = 64'(k + 1) << 20;
      send_req(1'b0, base, 13'd4096);
      wait_idle(100, ok);
      n_cmp++; if (ok !== 1'b1 || cap_data.size() != 8) begin n_bad++; $display("FAIL tag_req[%0d] got ok=%b beats=%0d exp 1/8", k, ok, cap_data.size()); end
      for (int j = 0; j < 8 && j < cap_data.size(); j++) begin
        logic [255:0] e;
        logic [255:0] cd;
        e = exp_hdr(1'b0, base + 64'(512 * j), 512, exp_tag);
        cd = cap_data[j];
        n_cmp++; if (cd !== e) begin n_bad++; $display("FAIL tag_hdr[%0d.%0d] got %h exp %h", k, j, cd, e); end
        if (prev == 8'hFF && cd[55:48] == 8'h00) wrap_seen = 1'b1;
        prev = cd[55:48];
        exp_tag = exp_tag + 8'd1;
      end
    end
    n_cmp++; if (wrap_seen !== 1'b1) begin n_bad++; $display("FAIL tag_wrap got %b exp 1", wrap_seen); end
  endtask

  task automatic test_reset_mid();
    logic ok, seen;
    clear_cap();
    for (int i = 0; i < 4; i++) wq.push_back(pay(32'hDEAD_0000 + 32'(i)));
    @(posedge clk); #1;
    send_req(1'b1, 64'h5000, 13'd128);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data === pay(32'hDEAD_0002)) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_third_beat got %b exp 1", seen); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx got v=%b sop=%b eop=%b exp 000", tx_valid, tx_sop, tx_eop); end
    rst = 1'b0;
    wq.delete();
    exp_tag = 8'h00;
    @(posedge clk); #1;
    clear_cap();
    send_req(1'b0, 64'h0, 13'd32);
    wait_idle(50, ok);
    n_cmp++; if (ok !== 1'b1 || cap_data.size() != 1) begin n_bad++; $display("FAIL rstmid_rd got ok=%b beats=%0d exp 1/1", ok, cap_data.size()); end
    if (cap_data.size() > 0) begin
      n_cmp++; if (cap_data[0] !== exp_hdr(1'b0, 64'h0, 32, exp_tag)) begin n_bad++; $display("FAIL rstmid_tag got %h exp %h", cap_data[0], exp_hdr(1'b0, 64'h0, 32, exp_tag)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_boundary_write();
    test_read();
    test_stall();
    test_zero_len();
    test_tag_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_tlp_tx_gen.md
PCIE_TLP_TX_GEN -- requirements
Module: pcie_tlp_tx_gen

Interface
REQ-001 The block SHALL have parameters: MPS, default 128, max write payload bytes per TLP; MRRS, default 512, max read request bytes per TLP.
REQ-002 The block SHALL run on one clock with a synchronous, active-high reset, with ports: clk in 1, clock; rst in 1, reset.
REQ-003 Request port: req_valid in 1; req_ready out 1; req_wr in 1 (1=MemWr, 0=MemRd); req_addr in 64, byte address, 32B aligned; req_len in 13, byte count, max 4096.
REQ-004 Write payload port: wdata_valid in 1; wdata_ready out 1; wdata in 256, 32B per beat.
REQ-005 TLP output port: tx_valid out 1; tx_ready in 1; tx_data out 256; tx_sop out 1, first beat of TLP; tx_eop out 1, last beat of TLP.

Function
REQ-006 The block SHALL contain the states IDLE, HDR and DATA.
REQ-007 IDLE: req_ready=1; a req_valid&&req_ready handshake SHALL latch req_wr, the address with bits [4:0] forced to 0, and the remaining length with bits [4:0] forced to 0.
REQ-008 A request with latched length 0 SHALL be accepted and dropped, staying in IDLE with no output beat.
REQ-009 Chunk size per TLP SHALL be min(remaining, limit, 4096 - addr[11:0]), where limit is MPS for writes and MRRS for reads; TLPs SHALL never cross a 4KB boundary.
REQ-010 HDR: the block SHALL drive one beat with tx_sop=1; tx_data[127:0] holds the 16B PCIE_PKG tlp_memory_req_header and tx_data[255:128] is 0.
REQ-011 Header content: fmt 011 for write, 001 for read; type 00000; length = chunk/4 in DW; requester_id 0x0200; byte_enable 0xFF; all other attribute fields 0.
REQ-012 Header address: byte-swapped address encoding per the PCIE_PKG header layout, with addr_l = addr[7:2].
REQ-013 Header tag: tag_l is 0 for writes; for reads, tag_l is an 8-bit counter value, incremented after each read header is accepted and wrapping 0xFF->0x00.
REQ-014 For a read, the header beat SHALL also have tx_eop=1.
REQ-015 After a read header is accepted, the block SHALL advance the address and remaining length, then go to HDR if remaining > 0, else to IDLE.
REQ-016 For a write, after header acceptance the block SHALL go to DATA, with a beat counter = chunk/32.
REQ-017 DATA: wdata_ready = (!tx_valid || tx_ready); each wdata handshake loads tx_data = wdata and decrements the counter; the last beat of the chunk carries tx_eop=1 and tx_sop=0.
REQ-018 After the last DATA beat, the block SHALL advance address and length by chunk, then go to HDR if remaining > 0, else to IDLE.
REQ-019 All tx_* outputs SHALL be registered; while tx_valid && !tx_ready, tx_data, tx_sop and tx_eop SHALL remain stable.
REQ-020 Header latency: the first header beat SHALL appear with tx_valid=1 exactly 1 cycle after the request handshake; with tx_ready held at 1, there SHALL be no bubble between TLPs or beats, given wdata is available.
REQ-021 wdata_ready SHALL be 0 outside DATA; req_ready SHALL be 0 outside IDLE.
REQ-022 Address arithmetic SHALL be 64-bit with natural wrap; remaining length is 13-bit unsigned and never underflows.

Reset
REQ-023 While rst=1, at the next clk edge: state=IDLE, tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0, tag counter=0, remaining=0; req_ready=1 after reset deasserts.
REQ-024 Reset mid-TLP SHALL abandon the TLP with no further beats; the next request starts fresh with tag 0.

Verification
REQ-025 Write, addr 0x1000, len 128, tx_ready=1 -> 5 beats: header with fmt 011, length 0x20 DW, sop on beat 1 only, eop on beat 5, payload matches wdata in order.
REQ-026 Write, addr 0x0FC0, len 256 -> three TLPs: 64B @0x0FC0 (length 16), 128B @0x1000 (length 32), 64B @0x1080 (length 16); beat counts 3/5/3.
REQ-027 Read, addr 0x2000, len 1024 -> two single-beat TLPs with sop=eop=1: length 128 DW, tags 0x00 and 0x01, addresses 0x2000 and 0x2200.
REQ-028 Write 128B with tx_ready toggling 1/0 every cycle and wdata_valid random -> tx_data stable during stalls, no beat lost or duplicated.
REQ-029 req_len=0 -> request accepted, no tx beat; 256 tag-incrementing reads -> tag wraps 0xFF->0x00.
REQ-030 rst asserted on the 3rd payload beat -> tx_valid=0 next cycle; a following read at 0x0 carries tag 0x00.
